traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised four-way intersection controller: Moore FSM sequencing through-green, yellow, protected left-turn and all-red phases for the NS and EW approaches, plus pedestrian walk signals and a night/fault flashing mode. Phase durations are counted in `tick` pulses from an external prescaler, so the block runs from the system clock at any rate. It sits between the tick generator and the lamp driver outputs of the intersection top level.

## Interface
- `T_G`, 40, through-green duration in ticks
- `T_Y`, 5, yellow duration in ticks (after green and after left turn)
- `T_LT`, 20, protected left-turn duration in ticks
- `T_AR`, 1, all-red clearance duration in ticks
- `TW`, 8, timer width; every duration must be ≥1 and ≤2^TW-1 (elaboration-time check)
- `clk` in 1 system clock
- `rst_n` in 1 reset; asynchronous, active-low; clock `clk`
- `tick` in 1 single-cycle timing enable; all durations count these
- `flash_req` in 1 level request for flashing mode
- `ped_req_ns`, `ped_req_ew` in 1 pedestrian button pulses
- `ns_lamp`, `ew_lamp` out 4 {lt, g, y, r}, one-hot per approach
- `ns_walk`, `ew_walk` out 1 walk lamp for crossing parallel to that approach
- `state_o` out 4 current state code
- `timer_o` out TW ticks elapsed in current state

## Operation
- States: ALL_RED, NS_G, NS_Y, EW_LT, EW_LT_Y, EW_G, EW_Y, NS_LT, NS_LT_Y, FLASH.
- Normal cycle: ALL_RED(T_AR) → NS_G(T_G) → NS_Y(T_Y) → EW_LT(T_LT) → EW_LT_Y(T_Y) → EW_G(T_G) → EW_Y(T_Y) → NS_LT(T_LT) → NS_LT_Y(T_Y) → NS_G.
- Lamps: NS_G → ns g; NS_Y, NS_LT_Y → ns y; NS_LT → ns lt; EW likewise. Approach shows r whenever it has no g/y/lt. Never two approaches non-red simultaneously (assertion).
- Timer: zero on state entry; increments on `tick`; state exits when `tick` && timer == duration-1. No `tick` → state held indefinitely.
- Flash entry: `flash_req`=1 in a green or left-turn state forces the matching yellow at next edge (timer 0); yellow and ALL_RED complete normally; ALL_RED with `flash_req`=1 → FLASH. Flash wins over a simultaneous normal transition.
- FLASH: ns y and ew r toggle together on each `tick` (phase bit starts on); other lamps and walks off. `flash_req`=0 → ALL_RED(T_AR) → NS_G.
- Walk: ns_walk only in NS_G, ew_walk only in EW_G (qualified by Configuration).

## Timing
- Reset: state ALL_RED, timer 0, `ns_lamp`=`ew_lamp`=4'b0001, walks 0, flash phase 0, pending requests cleared.
- Outputs registered, decoded from next state: lamps change on the same edge as `state_o`, no combinational path from inputs.
- Latency: `flash_req` to yellow lamp 1 cycle from a green state; state exit 1 cycle after terminal `tick`.
- Reset mid-phase: immediate return to ALL_RED reset values; first NS_G after T_AR ticks.
- Durations of 1: exit on the first `tick` in state.

## Configuration
- `TRAFFIC_PED_REQ_EN` defined: `ped_req_*` set a sticky pending bit; walk lit for the whole green only if pending at green entry; bit cleared on that entry; a request arriving during green waits for the next cycle.
- Undefined: walk lit for every corresponding green; `ped_req_*` ignored (ports remain).

## Structure
- Package `traffic_pkg`: state enum, lamp bit-index constants, default durations.
- Sub-module `phase_timer`: TW-bit tick counter with clear, terminal-count compare against a runtime duration.

## Test plan
- Reset, T_G=4,T_Y=2,T_LT=3,T_AR=1, `tick` every cycle → state order above, NS_G lasts exactly 4 cycles, ns_lamp=4'b0100 there.
- `tick` every 4th cycle → state durations scale ×4; timer_o holds between ticks.
- `flash_req`=1 at NS_G timer 1 → NS_Y next edge, then ALL_RED, FLASH; ns y toggles per tick; release → ALL_RED then NS_G.
- With macro, `ped_req_ew` pulse in NS_G → ew_walk=1 throughout next EW_G, 0 in following EW_G; without macro → ew_walk=1 every EW_G.
- `rst_n` low in EW_LT → outputs return to reset values immediately, no overlap of non-red lamps throughout.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller:
// state codes, one-hot lamp encodings and default phase durations.
package traffic_pkg;

  typedef enum logic [3:0] {
    ALL_RED = 4'd0,
    NS_G    = 4'd1,
    NS_Y    = 4'd2,
    EW_LT   = 4'd3,
    EW_LT_Y = 4'd4,
    EW_G    = 4'd5,
    EW_Y    = 4'd6,
    NS_LT   = 4'd7,
    NS_LT_Y = 4'd8,
    FLASH   = 4'd9
  } state_e;

  // Lamp vector is {lt, g, y, r}
  localparam int LMP_R  = 0;
  localparam int LMP_Y  = 1;
  localparam int LMP_G  = 2;
  localparam int LMP_LT = 3;

  localparam logic [3:0] L_R  = 4'b1 << LMP_R;
  localparam logic [3:0] L_Y  = 4'b1 << LMP_Y;
  localparam logic [3:0] L_G  = 4'b1 << LMP_G;
  localparam logic [3:0] L_LT = 4'b1 << LMP_LT;

  localparam int DEF_T_G  = 40;
  localparam int DEF_T_Y  = 5;
  localparam int DEF_T_LT = 20;
  localparam int DEF_T_AR = 1;
  localparam int DEF_TW   = 8;

  typedef struct packed {
    logic [3:0] ns;
    logic [3:0] ew;
  } lamps_t;

  // In FLASH the ns-yellow / ew-red pair blinks together and everything else is dark.
  function automatic lamps_t decode_lamps(state_e s, logic ph);
    lamps_t l;
    l.ns = L_R;
    l.ew = L_R;
    case (s)
      NS_G:          l.ns = L_G;
      NS_Y, NS_LT_Y: l.ns = L_Y;
      NS_LT:         l.ns = L_LT;
      EW_G:          l.ew = L_G;
      EW_Y, EW_LT_Y: l.ew = L_Y;
      EW_LT:         l.ew = L_LT;
      FLASH: begin
        l.ns = ph ? L_Y : 4'b0000;
        l.ew = ph ? L_R : 4'b0000;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Tick counter for the current phase: clears on state change, counts tick
// pulses, flags the terminal tick against a runtime duration.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          tick_i,
  input  logic [TW-1:0] dur_i,
  output logic [TW-1:0] cnt_o,
  output logic          done_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_i) cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = tick_i && (cnt_q == dur_i - TW'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-way intersection phase sequencer with left turns, walk lamps and flash mode.
// Define TRAFFIC_PED_REQ_EN to gate walk lamps on latched pedestrian requests.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_G  = DEF_T_G,
  parameter int T_Y  = DEF_T_Y,
  parameter int T_LT = DEF_T_LT,
  parameter int T_AR = DEF_T_AR,
  parameter int TW   = DEF_TW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          flash_req,
  input  logic          ped_req_ns,
  input  logic          ped_req_ew,
  output logic [3:0]    ns_lamp,
  output logic [3:0]    ew_lamp,
  output logic          ns_walk,
  output logic          ew_walk,
  output logic [3:0]    state_o,
  output logic [TW-1:0] timer_o
);

  localparam int TMAX = (2 ** TW) - 1;

  if (T_G < 1 || T_G > TMAX || T_Y < 1 || T_Y > TMAX ||
      T_LT < 1 || T_LT > TMAX || T_AR < 1 || T_AR > TMAX) begin : g_bad_dur
    $error("traffic_phase_ctrl: every duration must be in 1..2**TW-1");
  end

  state_e        state_q, state_d;
  logic          ph_q, ph_d;
  lamps_t        lamps_q, lamps_d;
  logic          ns_walk_q, ns_walk_d, ew_walk_q, ew_walk_d;
  logic [TW-1:0] dur;
  logic          done;

  always_comb begin
    case (state_q)
      NS_G, EW_G:                   dur = TW'(T_G);
      NS_Y, EW_Y, EW_LT_Y, NS_LT_Y: dur = TW'(T_Y);
      NS_LT, EW_LT:                 dur = TW'(T_LT);
      default:                      dur = TW'(T_AR);
    endcase
  end

  phase_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_d != state_q),
    .tick_i (tick),
    .dur_i  (dur),
    .cnt_o  (timer_o),
    .done_o (done)
  );

  // Go-phases drop to their yellow as soon as flash is requested; yellows and
  // all-red finish their time, then divert toward FLASH instead of the next go-phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ALL_RED: if (done) state_d = flash_req ? FLASH : NS_G;
      NS_G:    if (flash_req || done) state_d = NS_Y;
      EW_LT:   if (flash_req || done) state_d = EW_LT_Y;
      EW_G:    if (flash_req || done) state_d = EW_Y;
      NS_LT:   if (flash_req || done) state_d = NS_LT_Y;
      NS_Y:    if (done) state_d = flash_req ? ALL_RED : EW_LT;
      EW_LT_Y: if (done) state_d = flash_req ? ALL_RED : EW_G;
      EW_Y:    if (done) state_d = flash_req ? ALL_RED : NS_LT;
      NS_LT_Y: if (done) state_d = flash_req ? ALL_RED : NS_G;
      FLASH:   if (!flash_req) state_d = ALL_RED;
      default: state_d = ALL_RED;
    endcase
  end

  always_comb begin
    ph_d = 1'b0;
    if (state_d == FLASH) ph_d = (state_q != FLASH) ? 1'b1 : (ph_q ^ tick);
  end

  assign lamps_d = decode_lamps(state_d, ph_d);

`ifdef TRAFFIC_PED_REQ_EN
  logic pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic ns_entry, ew_entry, pend_ns_eff, pend_ew_eff;

  // A request is consumed at green entry; one arriving during green waits for the next.
  always_comb begin
    ns_entry    = (state_d == NS_G) && (state_q != NS_G);
    ew_entry    = (state_d == EW_G) && (state_q != EW_G);
    pend_ns_eff = pend_ns_q | ped_req_ns;
    pend_ew_eff = pend_ew_q | ped_req_ew;
    pend_ns_d   = ns_entry ? 1'b0 : pend_ns_eff;
    pend_ew_d   = ew_entry ? 1'b0 : pend_ew_eff;
    ns_walk_d   = ns_entry ? pend_ns_eff : ((state_d == NS_G) && ns_walk_q);
    ew_walk_d   = ew_entry ? pend_ew_eff : ((state_d == EW_G) && ew_walk_q);
  end
`else
  logic unused_ped;
  assign unused_ped = ped_req_ns ^ ped_req_ew;

  always_comb begin
    ns_walk_d = (state_d == NS_G);
    ew_walk_d = (state_d == EW_G);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ALL_RED;
      ph_q      <= 1'b0;
      lamps_q   <= '{ns: L_R, ew: L_R};
      ns_walk_q <= 1'b0;
      ew_walk_q <= 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      lamps_q   <= lamps_d;
      ns_walk_q <= ns_walk_d;
      ew_walk_q <= ew_walk_d;
`ifdef TRAFFIC_PED_REQ_EN
      pend_ns_q <= pend_ns_d;
      pend_ew_q <= pend_ew_d;
`endif
    end
  end

  assign ns_lamp = lamps_q.ns;
  assign ew_lamp = lamps_q.ew;
  assign ns_walk = ns_walk_q;
  assign ew_walk = ew_walk_q;
  assign state_o = state_q;

  a_no_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    !((|ns_lamp[3:1]) && (|ew_lamp[3:1])));

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: expected observations are queued as
// each step is driven and popped for comparison one cycle later.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int TW = 8;
`ifdef TRAFFIC_PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0, flash_req = 1'b0, ped_req_ns = 1'b0, ped_req_ew = 1'b0;
  logic [3:0]    ns_lamp, ew_lamp, state_o;
  logic          ns_walk, ew_walk;
  logic [TW-1:0] timer_o;

  traffic_phase_ctrl #(.T_G(4), .T_Y(2), .T_LT(3), .T_AR(1), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .flash_req(flash_req),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .ns_lamp(ns_lamp), .ew_lamp(ew_lamp), .ns_walk(ns_walk), .ew_walk(ew_walk),
    .state_o(state_o), .timer_o(timer_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [3:0]    ns;
    logic [3:0]    ew;
    logic          nsw;
    logic          eww;
    logic [TW-1:0] tmr;
  } obs_t;

  int   total = 0, bad = 0;
  obs_t exp_q[$];
  bit   ns_walk_en = 1'b0, ew_walk_en = 1'b0;

  function automatic obs_t model(state_e s, int t, bit ph);
    obs_t e;
    e.st = 4'(s);
    e.ns = 4'b0001;
    e.ew = 4'b0001;
    case (s)
      NS_G:          e.ns = 4'b0100;
      NS_Y, NS_LT_Y: e.ns = 4'b0010;
      NS_LT:         e.ns = 4'b1000;
      EW_G:          e.ew = 4'b0100;
      EW_Y, EW_LT_Y: e.ew = 4'b0010;
      EW_LT:         e.ew = 4'b1000;
      FLASH: begin
        e.ns = ph ? 4'b0010 : 4'b0000;
        e.ew = ph ? 4'b0001 : 4'b0000;
      end
      default: ;
    endcase
    e.nsw = (s == NS_G) && ns_walk_en;
    e.eww = (s == EW_G) && ew_walk_en;
    e.tmr = TW'(t);
    return e;
  endfunction

  task automatic compare(string tag);
    obs_t e, o;
    e = exp_q.pop_front();
    o = {state_o, ns_lamp, ew_lamp, ns_walk, ew_walk, timer_o};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed st=%0d ns=%b ew=%b w=%b%b t=%0d expected st=%0d ns=%b ew=%b w=%b%b t=%0d",
             tag, o.st, o.ns, o.ew, o.nsw, o.eww, o.tmr, e.st, e.ns, e.ew, e.nsw, e.eww, e.tmr);
    end
  endtask

  task automatic step(bit tk, bit fl, bit pew, state_e s, int t, bit ph, string tag);
    tick = tk; flash_req = fl; ped_req_ew = pew;
    exp_q.push_back(model(s, t, ph));
    @(posedge clk); #1;
    tick = 1'b0; ped_req_ew = 1'b0;
    compare(tag);
  endtask

  // Walks one whole phase starting at timer 0, ticking every `per` cycles.
  task automatic phase(state_e s, int dur, int per, state_e nx, bit pew);
    for (int i = 0; i < dur; i++) begin
      for (int p = 0; p < per; p++) begin
        bit first;
        first = pew && (i == 0) && (p == 0);
        if (p != per - 1)    step(1'b0, 1'b0, first, s, i, 1'b0, s.name());
        else if (i < dur - 1) step(1'b1, 1'b0, first, s, i + 1, 1'b0, s.name());
        else                 step(1'b1, 1'b0, first, nx, 0, 1'b1, s.name());
      end
    end
  endtask

  task automatic full_cycle(int per, bit pew_in_nsg, bit ew_walk_cycle);
    phase(NS_G,    4, per, NS_Y,    pew_in_nsg);
    phase(NS_Y,    2, per, EW_LT,   1'b0);
    phase(EW_LT,   3, per, EW_LT_Y, 1'b0);
    ew_walk_en = ew_walk_cycle;
    phase(EW_LT_Y, 2, per, EW_G,    1'b0);
    phase(EW_G,    4, per, EW_Y,    1'b0);
    ew_walk_en = 1'b0;
    phase(EW_Y,    2, per, NS_LT,   1'b0);
    phase(NS_LT,   3, per, NS_LT_Y, 1'b0);
    phase(NS_LT_Y, 2, per, NS_G,    1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!((|ns_lamp[3:1]) && (|ew_lamp[3:1]))) else begin
        bad++;
        $error("FAIL overlap observed ns=%b ew=%b expected at most one non-red", ns_lamp, ew_lamp);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(model(ALL_RED, 0, 1'b0));
    compare("reset");
    rst_n = 1'b1;
    ns_walk_en = !PED;

    // Tick every cycle; request an EW crossing during the first NS green.
    phase(ALL_RED, 1, 1, NS_G, 1'b0);
    full_cycle(1, 1'b1, 1'b1);
    // Tick every 4th cycle; no new request, so EW walk only in the default build.
    full_cycle(4, 1'b0, !PED);

    // Flash entry from green, blink, release.
    step(1'b1, 1'b0, 1'b0, NS_G,    1, 1'b0, "fl_pre");
    step(1'b0, 1'b1, 1'b0, NS_Y,    0, 1'b0, "fl_to_yel");
    step(1'b1, 1'b1, 1'b0, NS_Y,    1, 1'b0, "fl_yel");
    step(1'b1, 1'b1, 1'b0, ALL_RED, 0, 1'b0, "fl_ar");
    step(1'b1, 1'b1, 1'b0, FLASH,   0, 1'b1, "fl_on");
    step(1'b1, 1'b1, 1'b0, FLASH,   1, 1'b0, "fl_off");
    step(1'b1, 1'b1, 1'b0, FLASH,   2, 1'b1, "fl_on2");
    step(1'b0, 1'b1, 1'b0, FLASH,   2, 1'b1, "fl_hold");
    step(1'b0, 1'b0, 1'b0, ALL_RED, 0, 1'b0, "fl_rel");
    step(1'b0, 1'b0, 1'b0, ALL_RED, 0, 1'b0, "ar_hold");
    step(1'b1, 1'b0, 1'b0, NS_G,    0, 1'b0, "fl_nsg");

    // Asynchronous reset in the middle of EW left turn.
    phase(NS_G, 4, 1, NS_Y, 1'b0);
    phase(NS_Y, 2, 1, EW_LT, 1'b0);
    step(1'b1, 1'b0, 1'b0, EW_LT, 1, 1'b0, "ewlt_mid");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(model(ALL_RED, 0, 1'b0));
    compare("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    phase(ALL_RED, 1, 1, NS_G, 1'b0);
    step(1'b1, 1'b0, 1'b0, NS_G, 1, 1'b0, "post_rst");

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
